// File: rtl/pe_psum_accum.sv
// Partial-sum accumulator behind one PE column: sums cfg_len products per pixel,
// saturates to ACC_W bits, optional ReLU, and buffers results in a 2-entry FIFO.
module pe_psum_accum #(
  parameter int ACC_W = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              cfg_len,
  input  logic                    cfg_relu,
  input  logic                    prod_valid,
  input  logic signed [15:0]      prod_in,
  output logic                    prod_ready,
  output logic                    out_valid,
  output logic signed [ACC_W-1:0] out_data,
  input  logic                    out_ready,
  output logic                    busy
);

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [7:0]              cnt, len_q, len_new;
  logic                    relu_q, relu_eff;
  logic signed [ACC_W-1:0] acc, p_ext, sat_sum, sum, result;
  logic [ACC_W:0]          wide;
  logic                    accept, first, last, push, pop;

  logic [1:0]              fifo_cnt;
  logic                    rd_ptr, wr_ptr;
  logic signed [ACC_W-1:0] mem [2];

  always_comb begin
    accept   = prod_valid & prod_ready;
    first    = (cnt == 8'd0);
    len_new  = (cfg_len == 8'd0) ? 8'd1 : cfg_len;
    relu_eff = first ? cfg_relu : relu_q;
    p_ext    = {{(ACC_W-16){prod_in[15]}}, prod_in};
    // One guard bit: overflow shows up as disagreement between the top two bits.
    wide     = {acc[ACC_W-1], acc} + {p_ext[ACC_W-1], p_ext};
    if (wide[ACC_W] != wide[ACC_W-1])
      sat_sum = wide[ACC_W] ? ACC_MIN : ACC_MAX;
    else
      sat_sum = wide[ACC_W-1:0];
    sum    = first ? p_ext : sat_sum;
    last   = accept & (first ? (len_new == 8'd1) : (cnt == len_q - 8'd1));
    result = (relu_eff & sum[ACC_W-1]) ? '0 : sum;
    push   = last;
    pop    = out_valid & out_ready;
  end

  assign out_valid  = (fifo_cnt != 2'd0);
  assign prod_ready = (fifo_cnt != 2'd2);
  assign out_data   = mem[rd_ptr];
  assign busy       = (cnt != 8'd0) | (fifo_cnt != 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      len_q    <= 8'd1;
      relu_q   <= 1'b0;
      acc      <= '0;
      fifo_cnt <= '0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      mem[0]   <= '0;
      mem[1]   <= '0;
    end else begin
      if (accept) begin
        acc <= sum;
        cnt <= last ? 8'd0 : cnt + 8'd1;
        if (first) begin
          len_q  <= len_new;
          relu_q <= cfg_relu;
        end
      end
      if (push) begin
        mem[wr_ptr] <= result;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_psum_accum.sv
// Directed bench for pe_psum_accum: arithmetic-progression frame table plus
// hand-written backpressure, gap, ReLU and mid-frame reset sequences.
module tb_pe_psum_accum;

  localparam int ACC_W = 20;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [7:0]              cfg_len;
  logic                    cfg_relu;
  logic                    prod_valid;
  logic signed [15:0]      prod_in;
  logic                    prod_ready;
  logic                    out_valid;
  logic signed [ACC_W-1:0] out_data;
  logic                    out_ready;
  logic                    busy;

  int checks = 0;
  int errors = 0;

  pe_psum_accum #(.ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .cfg_len(cfg_len), .cfg_relu(cfg_relu),
    .prod_valid(prod_valid), .prod_in(prod_in), .prod_ready(prod_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // Frame whose products are base, base+step, base+2*step, ...
  typedef struct {
    logic [7:0] len;
    logic       relu;
    int         n;
    int         base;
    int         step;
    longint     exp;
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Offer one product and wait (bounded) until it is accepted.
  task automatic send(input int p);
    int k;
    k = 0;
    prod_valid = 1'b1;
    prod_in    = 16'(p);
    while (!prod_ready && k < 50) begin
      tick();
      k++;
    end
    if (!prod_ready) chk("send_timeout", 0, 1);
    tick();
    prod_valid = 1'b0;
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{len: 8'd9,  relu: 1'b0, n: 9,  base: 1,      step: 1,    exp: 45};
    vecs[1] = '{len: 8'd0,  relu: 1'b0, n: 1,  base: -7,     step: 0,    exp: -7};
    vecs[2] = '{len: 8'd40, relu: 1'b0, n: 40, base: 16384,  step: 0,    exp: 524287};
    vecs[3] = '{len: 8'd2,  relu: 1'b0, n: 2,  base: -16384, step: 0,    exp: -32768};
    vecs[4] = '{len: 8'd40, relu: 1'b0, n: 40, base: -16384, step: 0,    exp: -524288};
    vecs[5] = '{len: 8'd3,  relu: 1'b1, n: 3,  base: -10,    step: 5,    exp: 0};
    vecs[6] = '{len: 8'd3,  relu: 1'b0, n: 3,  base: -10,    step: 5,    exp: -15};
    // Saturates at the top by the 23rd term, then negative terms pull it back down.
    vecs[7] = '{len: 8'd60, relu: 1'b0, n: 60, base: 32000,  step: -800, exp: 372287};

    rst = 1'b1; cfg_len = 8'd1; cfg_relu = 1'b0; prod_valid = 1'b0;
    prod_in = '0; out_ready = 1'b1;
    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_prod_ready", prod_ready, 1);
    rst = 1'b0;
    tick();

    foreach (vecs[v]) begin
      cfg_len  = vecs[v].len;
      cfg_relu = vecs[v].relu;
      for (int i = 0; i < vecs[v].n; i++) begin
        send(vecs[v].base + i * vecs[v].step);
        // Scramble the config after the first term; the frame must ignore it.
        cfg_len  = vecs[v].len ^ 8'h5A;
        cfg_relu = ~vecs[v].relu;
        if (i == 0 && vecs[v].n > 1) begin
          chk($sformatf("v%0d_busy_mid", v), busy, 1);
          chk($sformatf("v%0d_no_early_out", v), out_valid, 0);
        end
      end
      chk($sformatf("v%0d_out_valid", v), out_valid, 1);
      chk($sformatf("v%0d_out_data", v), out_data, vecs[v].exp);
      tick();
      chk($sformatf("v%0d_drained", v), out_valid, 0);
      chk($sformatf("v%0d_idle", v), busy, 0);
    end

    // ReLU on a negative sum, then the same terms without ReLU.
    cfg_len = 8'd3; cfg_relu = 1'b1;
    send(-100); send(20); send(30);
    chk("relu_on_data", out_data, 0);
    chk("relu_on_valid", out_valid, 1);
    tick();
    cfg_relu = 1'b0;
    send(-100); send(20); send(30);
    chk("relu_off_data", out_data, -50);
    tick();

    // Backpressure: two results fill the FIFO, the third product is held off.
    out_ready = 1'b0; cfg_len = 8'd1;
    send(5); send(6);
    prod_valid = 1'b1; prod_in = 16'sd7;
    chk("bp_ready_low", prod_ready, 0);
    chk("bp_head", out_data, 5);
    tick();
    chk("bp_head_stable", out_data, 5);
    chk("bp_still_full", prod_ready, 0);
    out_ready = 1'b1;
    tick();
    chk("bp_pop1", out_data, 6);
    chk("bp_ready_back", prod_ready, 1);
    tick();
    prod_valid = 1'b0;
    chk("bp_pop2_valid", out_valid, 1);
    chk("bp_pop2", out_data, 7);
    tick();
    chk("bp_empty", out_valid, 0);
    chk("bp_idle", busy, 0);

    // Idle gaps inside a frame and a mid-frame length change.
    cfg_len = 8'd4;
    send(1);
    cfg_len = 8'd2;
    send(2);
    for (int g = 0; g < 3; g++) begin
      tick();
      chk("gap_no_out", out_valid, 0);
    end
    chk("gap_busy", busy, 1);
    send(3);
    chk("gap_not_yet", out_valid, 0);
    send(4);
    chk("gap_data", out_data, 10);
    tick();

    // Reset with a queued result and a partial frame; product in reset cycle dropped.
    out_ready = 1'b0; cfg_len = 8'd1;
    send(11);
    cfg_len = 8'd9;
    send(1); send(2);
    rst = 1'b1; prod_valid = 1'b1; prod_in = 16'sd99;
    tick();
    rst = 1'b0; prod_valid = 1'b0;
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_ready", prod_ready, 1);
    out_ready = 1'b1; cfg_len = 8'd2;
    send(8);
    chk("mrst_no_early", out_valid, 0);
    send(9);
    chk("mrst_valid", out_valid, 1);
    chk("mrst_data", out_data, 17);
    tick();
    chk("mrst_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
